// File: rtl/lottery_pkg.sv
// lottery_pkg: shared widths, FSM states and LFSR helpers for the lottery draw path
package lottery_pkg;
    localparam int NUM_W = 5;
    localparam int NUM_PICKS = 4;
    localparam int LFSR_W = 8;
    typedef enum logic [1:0] {IDLE, DRAW, FIN} state_t;
    function automatic logic [NUM_W-1:0] cand_of(input logic [LFSR_W-1:0] q);
        return q[NUM_W-1:0];
    endfunction
endpackage

// File: rtl/draw_lfsr.sv
// draw_lfsr: free-running 8-bit Fibonacci LFSR (taps 8,6,5,4), period 255
module draw_lfsr #(
    parameter int LFSR_W = 8,
    parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    output logic [LFSR_W-1:0] q
);
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= SEED;
        else q <= {q[LFSR_W-2:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
endmodule

// File: rtl/draw_generator.sv
// draw_generator: draws four distinct numbers in 1..MAX_NUM from an LFSR, aborting after MAX_TRIES candidates
module draw_generator import lottery_pkg::*; #(
    parameter int MAX_NUM = 31,
    parameter logic [LFSR_W-1:0] SEED = 8'hA5,
    parameter int MAX_TRIES = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [NUM_W-1:0] w1,
    output logic [NUM_W-1:0] w2,
    output logic [NUM_W-1:0] w3,
    output logic [NUM_W-1:0] w4,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int TW = $clog2(MAX_TRIES + 1);
    state_t state, state_n;
    logic [NUM_W-1:0] w [NUM_PICKS];
    logic [NUM_W-1:0] w_n [NUM_PICKS];
    logic [1:0] idx, idx_n;
    logic [TW-1:0] tries, tries_n;
    logic busy_n, done_n, err_n, hit, valid, last;
    logic [LFSR_W-1:0] lfsr;
    logic [NUM_W-1:0] cand;

    draw_lfsr #(.LFSR_W(LFSR_W), .SEED(SEED)) u_lfsr (.clk(clk), .rst(rst), .q(lfsr));

    assign cand = cand_of(lfsr);
    assign w1 = w[0];
    assign w2 = w[1];
    assign w3 = w[2];
    assign w4 = w[3];

    // empty slots hold zero, which is already rejected, so all four can be compared
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < NUM_PICKS; i++) hit = hit | (cand == w[i]);
        valid = (cand != '0) && (cand <= NUM_W'(MAX_NUM)) && !hit;
        last = idx == 2'(NUM_PICKS - 1);
    end

    always_comb begin
        state_n = state;
        w_n = w;
        idx_n = idx;
        tries_n = tries;
        busy_n = busy;
        done_n = done;
        err_n = err;
        if (state != DRAW && start) begin
            state_n = DRAW;
            w_n = '{default: '0};
            idx_n = '0;
            tries_n = '0;
            busy_n = 1'b1;
            done_n = 1'b0;
            err_n = 1'b0;
        end else if (state == DRAW) begin
            tries_n = tries + 1'b1;
            if (valid) begin
                w_n[idx] = cand;
                idx_n = idx + 2'd1;
            end
            // a 4th accept on the final try still completes the draw
            if (valid && last) begin
                busy_n = 1'b0;
                done_n = 1'b1;
                state_n = FIN;
            end else if (tries == TW'(MAX_TRIES - 1)) begin
                busy_n = 1'b0;
                err_n = 1'b1;
                w_n = '{default: '0};
                state_n = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            w <= '{default: '0};
            idx <= '0;
            tries <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
        end else begin
            state <= state_n;
            w <= w_n;
            idx <= idx_n;
            tries <= tries_n;
            busy <= busy_n;
            done <= done_n;
            err <= err_n;
        end
endmodule

// File: tb/tb_draw_generator.sv
// tb_draw_generator: directed checks of three draw_generator configurations against a reference draw model
module tb_draw_generator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_s [3];
    wire [19:0] wv_s [3];
    wire busy_s [3];
    wire done_s [3];
    wire err_s [3];
    logic [7:0] lm;
    int n_chk = 0;
    int n_fail = 0;

    draw_generator u_a (.clk(clk), .rst(rst), .start(start_s[0]),
        .w1(wv_s[0][4:0]), .w2(wv_s[0][9:5]), .w3(wv_s[0][14:10]), .w4(wv_s[0][19:15]),
        .busy(busy_s[0]), .done(done_s[0]), .err(err_s[0]));
    draw_generator #(.MAX_NUM(4)) u_b (.clk(clk), .rst(rst), .start(start_s[1]),
        .w1(wv_s[1][4:0]), .w2(wv_s[1][9:5]), .w3(wv_s[1][14:10]), .w4(wv_s[1][19:15]),
        .busy(busy_s[1]), .done(done_s[1]), .err(err_s[1]));
    draw_generator #(.MAX_NUM(3), .MAX_TRIES(20)) u_c (.clk(clk), .rst(rst), .start(start_s[2]),
        .w1(wv_s[2][4:0]), .w2(wv_s[2][9:5]), .w3(wv_s[2][14:10]), .w4(wv_s[2][19:15]),
        .busy(busy_s[2]), .done(done_s[2]), .err(err_s[2]));

    always #5 clk = ~clk;

    function automatic logic [7:0] step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    // all three DUTs share reset and seed, so one LFSR model tracks them all
    always @(posedge clk or posedge rst)
        if (rst) lm <= 8'hA5;
        else lm <= step(lm);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // downstream readiness: all slots nonzero, within range and pairwise distinct
    function automatic logic rdy(input logic [19:0] v, input int maxn);
        logic r;
        r = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (v[i*5+:5] == 0 || v[i*5+:5] > maxn) r = 1'b0;
            for (int j = 0; j < i; j++) if (v[i*5+:5] == v[j*5+:5]) r = 1'b0;
        end
        return r;
    endfunction

    task automatic model(input logic [7:0] l0, input int maxn, input int maxt,
                         output logic [19:0] wv, output int k, output int a2);
        logic [7:0] l;
        logic [4:0] c;
        int n;
        l = l0;
        wv = '0;
        n = 0;
        k = 0;
        a2 = 0;
        for (int t = 0; t < maxt && n < 4; t++) begin
            c = l[4:0];
            if (c != 0 && c <= maxn && c != wv[4:0] && c != wv[9:5] && c != wv[14:10] && c != wv[19:15]) begin
                wv[n*5+:5] = c;
                n++;
                if (n == 2) a2 = t + 1;
            end
            k = t + 1;
            l = step(l);
        end
        if (n < 4) begin
            wv = '0;
            k = -1;
        end
    endtask

    task automatic pulse(input int d, output logic [7:0] l0);
        @(negedge clk);
        start_s[d] = 1'b1;
        @(negedge clk);
        start_s[d] = 1'b0;
        l0 = lm;
    endtask

    task automatic run_draw(input int d, input int maxn, input int maxt, input int poke);
        logic [7:0] l0;
        logic [19:0] wv, hold;
        int k, a2, cnt;
        pulse(d, l0);
        check("busy_after_start", busy_s[d], 1);
        check("done_after_start", done_s[d], 0);
        check("err_after_start", err_s[d], 0);
        model(l0, maxn, maxt, wv, k, a2);
        cnt = 0;
        while (!done_s[d] && !err_s[d] && cnt < 300) begin
            @(negedge clk);
            cnt++;
            start_s[d] = (cnt == poke);
        end
        start_s[d] = 1'b0;
        if (k > 0) begin
            check("draw_cycles", cnt, k);
            check("draw_w", wv_s[d], wv);
            check("draw_err", err_s[d], 0);
            check("draw_rdy", rdy(wv_s[d], maxn), 1);
            hold = wv_s[d];
            repeat (3) @(negedge clk);
            check("w_stable", wv_s[d], hold);
            check("done_held", done_s[d], 1);
        end else begin
            check("abort_cycles", cnt, maxt);
            check("abort_err", err_s[d], 1);
            check("abort_done", done_s[d], 0);
            check("abort_busy", busy_s[d], 0);
            check("abort_w", wv_s[d], 0);
        end
    endtask

    always @(negedge clk)
        if (!rst) begin
            if (busy_s[0]) check("sysrdy_busy", rdy(wv_s[0], 31), 0);
            if (done_s[0]) check("sysrdy_done", rdy(wv_s[0], 31), 1);
        end

    initial begin
        logic [7:0] l0;
        logic [19:0] wv;
        int k, a2;
        for (int d = 0; d < 3; d++) start_s[d] = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("rst_w", wv_s[d], 0);
            check("rst_busy", busy_s[d], 0);
            check("rst_done", done_s[d], 0);
            check("rst_err", err_s[d], 0);
        end
        rst = 1'b0;
        run_draw(0, 31, 255, 0);
        run_draw(0, 31, 255, 2);
        for (int i = 0; i < 10; i++) begin
            repeat ((i * 3) % 7 + i) @(negedge clk);
            run_draw(1, 4, 255, 0);
        end
        run_draw(2, 3, 20, 0);
        repeat (3) @(negedge clk);
        check("err_held", err_s[2], 1);
        run_draw(2, 3, 20, 0);
        pulse(0, l0);
        model(l0, 31, 255, wv, k, a2);
        repeat (a2) @(negedge clk);
        check("partial_w12", wv_s[0][9:0], wv[9:0]);
        check("partial_w34", wv_s[0][19:10], 0);
        check("partial_busy", busy_s[0], 1);
        #2 rst = 1'b1;
        #1;
        check("midrst_w", wv_s[0], 0);
        check("midrst_busy", busy_s[0], 0);
        check("midrst_done", done_s[0], 0);
        check("midrst_err", err_s[0], 0);
        @(negedge clk);
        rst = 1'b0;
        run_draw(0, 31, 255, 0);
        for (int i = 0; i < 100; i++) begin
            repeat ($urandom_range(0, 9)) @(negedge clk);
            run_draw(0, 31, 255, 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
